// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle CPU.
// A start request initialises the PC for one cycle and then enables execution.
// Load/store instructions are stalled for MEM_LAT extra cycles before they commit.
// Execution ends at halt (DONE) or when the watchdog expires (TIMEOUT).
// cycle_count counts RUN cycles since the last INIT.
module cpu_run_ctrl #(
    parameter int CYCLE_W    = 16,
    parameter int MAX_CYCLES = 1000,
    parameter int MEM_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               mem_op,
    output logic               pc_init,
    output logic               pc_en,
    output logic               commit_en,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    // cycle_count holds this value during the last cycle the watchdog allows.
    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [2:0]         STALL_MAX  = 3'(MEM_LAT);

    state_t     state;
    logic [2:0] stall_cnt;
    logic       at_limit;
    logic       mem_stall;

    // stall_cnt only ever counts up to STALL_MAX and then clears, so an
    // equality test is the same as stall_cnt < MEM_LAT. It also behaves
    // correctly when MEM_LAT is 0.
    assign at_limit  = (cycle_count == LAST_CYCLE);
    assign mem_stall = mem_op && (stall_cnt != STALL_MAX);

    // These flags depend only on the state.
    assign pc_init = (state == INIT);
    assign busy    = (state == INIT) || (state == RUN);
    assign done    = (state == DONE) || (state == TIMEOUT);
    assign timeout = (state == TIMEOUT);

    // Execution may advance only in an unstalled RUN cycle that is not halting
    // and has not reached the watchdog limit.
    always_comb begin
        pc_en     = 1'b0;
        commit_en = 1'b0;
        if (state == RUN && !halt && !at_limit && !mem_stall) begin
            pc_en     = 1'b1;
            commit_en = 1'b1;
        end
    end

    // State machine, stall counter and cycle counter.
    // NOTE: reset is synchronous, and every register here uses non-blocking
    // assignment so that all of them see the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stall_cnt   <= 3'd0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= INIT;
                        stall_cnt   <= 3'd0;
                        cycle_count <= '0;
                    end
                end
                INIT: begin
                    state       <= RUN;
                    stall_cnt   <= 3'd0;
                    cycle_count <= '0;
                end
                RUN: begin
                    cycle_count <= cycle_count + CYCLE_W'(1);
                    if (halt) begin
                        // halt takes priority over the watchdog and any stall.
                        state     <= DONE;
                        stall_cnt <= 3'd0;
                    end else if (at_limit) begin
                        state     <= TIMEOUT;
                        stall_cnt <= 3'd0;
                    end else if (mem_stall) begin
                        stall_cnt <= stall_cnt + 3'd1;
                    end else begin
                        stall_cnt <= 3'd0;
                    end
                end
                DONE, TIMEOUT: begin
                    // Terminal states. Only a new start request leaves them.
                    if (start) begin
                        state       <= INIT;
                        stall_cnt   <= 3'd0;
                        cycle_count <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    stall_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with the default parameters
// (CYCLE_W=16, MAX_CYCLES=1000, MEM_LAT=1). For each cycle the bench pushes
// the expected output vector to a queue, drives the inputs, and then pops and
// compares the vector one time unit later, well away from the rising edge.
module tb_cpu_run_ctrl;

    localparam int CYCLE_W = 16;

    // Flag vector order: {pc_init, pc_en, commit_en, busy, done, timeout}
    localparam logic [5:0] F_IDLE = 6'b000000;
    localparam logic [5:0] F_INIT = 6'b100100;
    localparam logic [5:0] F_RUN  = 6'b011100;
    localparam logic [5:0] F_HOLD = 6'b000100;
    localparam logic [5:0] F_DONE = 6'b000010;
    localparam logic [5:0] F_TMO  = 6'b000011;

    typedef struct packed {
        logic [5:0]         flags;
        logic [CYCLE_W-1:0] cc;
    } obs_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               halt;
    logic               mem_op;
    logic               pc_init;
    logic               pc_en;
    logic               commit_en;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [CYCLE_W-1:0] cycle_count;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    cpu_run_ctrl #(
        .CYCLE_W   (CYCLE_W),
        .MAX_CYCLES(1000),
        .MEM_LAT   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .mem_op     (mem_op),
        .pc_init    (pc_init),
        .pc_en      (pc_en),
        .commit_en  (commit_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one cycle: drive the inputs, queue the expected outputs, compare
    // them, and then move on to the next falling edge.
    task automatic step(input string tag, input logic r, input logic s,
                        input logic h, input logic m,
                        input logic [5:0] f, input int cc);
        obs_t obs;
        obs_t expv;
        reset  = r;
        start  = s;
        halt   = h;
        mem_op = m;
        exp_q.push_back('{flags: f, cc: CYCLE_W'(cc)});
        #1;
        obs  = '{flags: {pc_init, pc_en, commit_en, busy, done, timeout},
                 cc: cycle_count};
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed flags=%b count=%0d, expected flags=%b count=%0d",
                   tag, obs.flags, obs.cc, expv.flags, expv.cc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        halt   = 1'b0;
        mem_op = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Test 1: reset, start pulse, halt on RUN cycle 5
        step("reset_hold",   1, 0, 0, 0, F_IDLE, 0);
        step("idle_start",   0, 1, 0, 0, F_IDLE, 0);
        step("t1_init",      0, 0, 0, 0, F_INIT, 0);
        for (int k = 1; k <= 4; k++)
            step("t1_run",   0, 0, 0, 0, F_RUN, k - 1);
        step("t1_halt",      0, 0, 1, 0, F_HOLD, 4);
        step("t1_done",      0, 0, 0, 0, F_DONE, 5);
        step("t1_done_ign",  0, 0, 1, 1, F_DONE, 5);

        // Test 6 + Test 2: restart from DONE, start held high during RUN,
        // one load on RUN cycles 2-3, halt on RUN cycle 6
        step("t6_done_start", 0, 1, 0, 0, F_DONE, 5);
        step("t6_init",      0, 1, 0, 0, F_INIT, 0);
        step("t2_c1",        0, 1, 0, 0, F_RUN,  0);
        step("t2_c2_stall",  0, 1, 0, 1, F_HOLD, 1);
        step("t2_c3_commit", 0, 1, 0, 1, F_RUN,  2);
        step("t2_c4",        0, 1, 0, 0, F_RUN,  3);
        step("t2_c5",        0, 1, 0, 0, F_RUN,  4);
        step("t2_c6_halt",   0, 1, 1, 0, F_HOLD, 5);
        step("t2_done",      0, 0, 0, 0, F_DONE, 6);

        // Test 3: watchdog expiry without halt
        step("t3_start",     0, 1, 0, 0, F_DONE, 6);
        step("t3_init",      0, 0, 0, 0, F_INIT, 0);
        for (int k = 1; k <= 999; k++)
            step("t3_run",   0, 0, 0, 0, F_RUN, k - 1);
        step("t3_wd_cycle",  0, 0, 0, 0, F_HOLD, 999);
        step("t3_timeout",   0, 0, 0, 0, F_TMO, 1000);
        step("t3_tmo_ign",   0, 0, 1, 1, F_TMO, 1000);

        // Test 4: halt in the watchdog cycle gives DONE
        step("t4_start",     0, 1, 0, 0, F_TMO, 1000);
        step("t4_init",      0, 0, 0, 0, F_INIT, 0);
        for (int k = 1; k <= 999; k++)
            step("t4_run",   0, 0, 0, 0, F_RUN, k - 1);
        step("t4_halt_wd",   0, 0, 1, 0, F_HOLD, 999);
        step("t4_done",      0, 0, 0, 0, F_DONE, 1000);

        // Test 5: reset during RUN cycle 3 (mid-stall), then restart
        step("t5_start",     0, 1, 0, 0, F_DONE, 1000);
        step("t5_init",      0, 0, 0, 0, F_INIT, 0);
        step("t5_c1",        0, 0, 0, 0, F_RUN,  0);
        step("t5_c2",        0, 0, 0, 0, F_RUN,  1);
        step("t5_c3_reset",  1, 0, 0, 1, F_HOLD, 2);
        step("t5_idle",      0, 0, 0, 0, F_IDLE, 0);
        step("t5_restart",   0, 1, 0, 0, F_IDLE, 0);
        step("t5_init2",     0, 0, 0, 0, F_INIT, 0);
        step("t5_stall_c1",  0, 0, 0, 1, F_HOLD, 0);
        step("t5_halt_stall", 0, 0, 1, 1, F_HOLD, 1);
        step("t5_done",      0, 0, 0, 0, F_DONE, 2);

        // Boundary: halt in the very first RUN cycle
        step("b_start",      0, 1, 0, 0, F_DONE, 2);
        step("b_init",       0, 0, 0, 0, F_INIT, 0);
        step("b_halt_c1",    0, 0, 1, 0, F_HOLD, 0);
        step("b_done",       0, 0, 0, 0, F_DONE, 1);

        // A MEM_LAT=1 load (mem_op held for two cycles) right after INIT
        step("m_start",      0, 1, 0, 0, F_DONE, 1);
        step("m_init",       0, 0, 0, 0, F_INIT, 0);
        step("m_stall",      0, 0, 0, 1, F_HOLD, 0);
        step("m_commit",     0, 0, 0, 1, F_RUN,  1);
        step("m_next_stall", 0, 0, 0, 1, F_HOLD, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
